// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//   Parallel-to-serial transmitter for WIDTH-bit words. A word is accepted on a
//   valid/ready handshake and shifted out MSB-first, one bit per enabled clock,
//   followed by an optional even-parity bit and a one-cycle completion pulse.
//   `enable` = 0 freezes all state and gates the qualified outputs, so one
//   enable line can stall the whole register datapath.
//
//   Optional feature: define WORD_SERIALIZER_PARITY_EN to append a parity bit
//   (XOR of the accepted word) after the data bits.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset
//   enable        in   1 = advance, 0 = freeze
//   load_valid    in   producer offers value_in
//   value_in      in   WIDTH-bit word, sampled on accept
//   load_ready    out  block can accept a word this cycle
//   serial_out    out  current serial bit
//   serial_valid  out  serial_out carries a frame bit
//   frame_start   out  MSB of a frame is on serial_out
//   done          out  one-cycle pulse after the last frame bit
// -----------------------------------------------------------------------------
module word_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] value_in,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             done
);

  // One extra counter bit so the count never wraps inside a frame.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef WORD_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic accept;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
`ifdef WORD_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
`ifdef WORD_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next state. Nothing moves while enable is low.
  // ---------------------------------------------------------------------------
  assign accept = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef WORD_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shreg_d = value_in;
            cnt_d   = '0;
`ifdef WORD_SERIALIZER_PARITY_EN
            par_d   = ^value_in;
`endif
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef WORD_SERIALIZER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_DONE;
`endif
          end
        end
`ifdef WORD_SERIALIZER_PARITY_EN
        S_PARITY: state_d = S_DONE;
`endif
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. serial_out depends on state only, so it naturally holds while
  // frozen; the strobes are qualified by enable (and load_ready by reset).
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ready   = (state_q == S_IDLE) && enable && !reset;
    frame_start  = (state_q == S_SHIFT) && (cnt_q == '0) && enable;
    done         = (state_q == S_DONE) && enable;
    serial_valid = 1'b0;
    serial_out   = 1'b0;
    case (state_q)
      S_SHIFT: begin
        serial_out   = shreg_q[WIDTH-1];
        serial_valid = enable;
      end
`ifdef WORD_SERIALIZER_PARITY_EN
      S_PARITY: begin
        serial_out   = par_q;
        serial_valid = enable;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_serializer
//   Directed self-checking bench for word_serializer (WIDTH = 16). Inputs are
//   driven 1 ns after each rising edge; outputs are sampled 1 ns later, well
//   away from the active edge. Expected bit streams come from the words
//   themselves (MSB first); parity frames are checked when the parity macro
//   is defined for the build.
// -----------------------------------------------------------------------------
module tb_word_serializer;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         load_valid;
  logic [W-1:0] value_in;
  logic         load_ready;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_start;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  word_serializer #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .load_valid   (load_valid),
    .value_in     (value_in),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept w in the current cycle and check the whole frame. Optionally keeps
  // load_valid high with hold_w during the frame, and optionally drops enable
  // for 3 cycles after bit index pause_at. Returns in the IDLE cycle after done.
  task automatic run_frame(input logic [W-1:0] w, input int pause_at,
                           input logic hold, input logic [W-1:0] hold_w);
    enable     = 1'b1;
    load_valid = 1'b1;
    value_in   = w;
    #1;
    chk("acc_ready", load_ready, 1);
    tick();
    load_valid = hold;
    value_in   = hold_w;
    for (int i = 0; i < W; i++) begin
      #1;
      chk("bit_valid", serial_valid, 1);
      chk("bit_value", serial_out, w[W-1-i]);
      chk("bit_fstart", frame_start, (i == 0) ? 1 : 0);
      chk("bit_nodone", done, 0);
      chk("bit_nready", load_ready, 0);
      tick();
      if (i == pause_at) begin
        enable = 1'b0;
        for (int p = 0; p < 3; p++) begin
          #1;
          chk("pause_valid", serial_valid, 0);
          chk("pause_hold", serial_out, w[W-2-i]);
          chk("pause_fstart", frame_start, 0);
          chk("pause_done", done, 0);
          chk("pause_ready", load_ready, 0);
          tick();
        end
        enable = 1'b1;
      end
    end
`ifdef WORD_SERIALIZER_PARITY_EN
    #1;
    chk("par_valid", serial_valid, 1);
    chk("par_value", serial_out, ^w);
    chk("par_fstart", frame_start, 0);
    chk("par_nodone", done, 0);
    tick();
`endif
    #1;
    chk("done_pulse", done, 1);
    chk("done_valid", serial_valid, 0);
    chk("done_ready", load_ready, 0);
    tick();
    #1;
    chk("post_ready", load_ready, 1);
    chk("post_done", done, 0);
    chk("post_valid", serial_valid, 0);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    load_valid = 1'b0;
    value_in   = '0;

    // Reset state, with valid offered to show reset beats accept.
    load_valid = 1'b1;
    value_in   = 16'hBEEF;
    #1;
    chk("rst_ready", load_ready, 0);
    tick();
    #1;
    chk("rst_ready2", load_ready, 0);
    chk("rst_sout", serial_out, 0);
    chk("rst_valid", serial_valid, 0);
    chk("rst_fstart", frame_start, 0);
    chk("rst_done", done, 0);
    load_valid = 1'b0;
    tick();
    reset = 1'b0;

    // Idle: ready high, nothing transmitted, no done.
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("idle_ready", load_ready, 1);
      chk("idle_valid", serial_valid, 0);
      chk("idle_done", done, 0);
      tick();
    end
    enable = 1'b0;
    #1;
    chk("idle_frozen_ready", load_ready, 0);
    tick();
    enable = 1'b1;

    // Basic frame.
    run_frame(16'h8001, -1, 1'b0, 16'h0000);

    // Hold valid with FFFF through the A5F0 frame; FFFF is taken only after.
    run_frame(16'hA5F0, -1, 1'b1, 16'hFFFF);
    run_frame(16'hFFFF, -1, 1'b0, 16'h0000);

    // Enable pause after the 5th bit.
    run_frame(16'h00FF, 4, 1'b0, 16'h0000);

    // Reset during the 8th bit of 1234.
    load_valid = 1'b1;
    value_in   = 16'h1234;
    #1;
    chk("r_acc_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("r_bit_value", serial_out, value_in[W-1-i]);
      chk("r_bit_valid", serial_valid, 1);
      if (i < 7) tick();
    end
    reset = 1'b1;
    #1;
    chk("r_mid_ready", load_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("r_after_valid", serial_valid, 0);
    chk("r_after_ready", load_ready, 1);
    chk("r_after_sout", serial_out, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      chk("r_no_done", done, 0);
    end
    run_frame(16'h5A3C, -1, 1'b0, 16'h0000);

`ifdef WORD_SERIALIZER_PARITY_EN
    run_frame(16'h0007, -1, 1'b0, 16'h0000);
    run_frame(16'h0003, -1, 1'b0, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial transmitter for 16-bit words held in the team's `Register` block, forming the outbound end of the register datapath. It accepts a word on a valid/ready load handshake and shifts it out MSB-first, one bit per clock, with a frame marker and a completion pulse. An optional parity bit closes each frame. It obeys the same `enable` hold semantics as the storage register, so one enable line can freeze the whole path.

## Interface
- `WIDTH`, 16, data word width in bits; must be ≥ 2.
- `clock`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- `enable`  in  1  1 = advance; 0 = freeze all state.
- `load_valid`  in  1  producer has a word on `value_in`.
- `value_in`  in  WIDTH  word to transmit, sampled on accept.
- `load_ready`  out  1  block can accept a word this cycle.
- `serial_out`  out  1  current serial bit.
- `serial_valid`  out  1  `serial_out` carries a frame bit this cycle.
- `frame_start`  out  1  first bit (MSB) of a frame is on `serial_out`.
- `done`  out  1  one-cycle pulse after the last frame bit.

## Operation
- States:
  - IDLE: waiting for a word.
  - SHIFT: transmitting data bits.
  - PARITY: transmitting the parity bit; exists only with the macro.
  - DONE: one-cycle completion state.
- Accept rule: a word is accepted on a rising edge where `load_valid && load_ready`. `load_ready = (state==IDLE) && enable && !reset`, combinational.
- On accept:
  - Latch `value_in` into the shift register.
  - Clear the bit counter.
  - Go to SHIFT.
- SHIFT behaviour:
  - `serial_out` = shift register MSB.
  - `serial_valid` = `enable`.
  - Each enabled edge shifts left by 1 (zero fill) and increments the counter.
  - After WIDTH bits have been emitted, go to PARITY if the macro is defined, otherwise DONE.
- Counter: width is `$clog2(WIDTH)+1`, so it never wraps within a frame.
- `frame_start`: 1 only in SHIFT with counter == 0 and `enable` = 1.
- DONE:
  - `done` = `enable`; `serial_valid` = 0; `load_ready` = 0.
  - Next enabled edge goes to IDLE.
- `load_valid` outside IDLE is ignored. `value_in` is not sampled again until the next accept.
- `enable` = 0:
  - State, counter and shift register hold.
  - `serial_valid`, `frame_start`, `done` and `load_ready` are forced to 0.
  - `serial_out` holds its current value.
  - The frame resumes exactly where it stopped when `enable` returns to 1.
- Reset:
  - Every edge with `reset` = 1 forces IDLE and clears the counter and shift register.
  - Takes priority over `enable` and over an accept in the same cycle.
  - A frame in progress is abandoned with no `done`.
- Reset values of outputs: `load_ready` 0 (while reset is high), `serial_out` 0, `serial_valid` 0, `frame_start` 0, `done` 0.

## Timing
- Accept at edge k:
  - Data bit i (MSB = bit WIDTH-1 first) is on `serial_out` during cycle k+1+(WIDTH-1-i).
  - For WIDTH = 16: bits occupy cycles k+1..k+16.
  - `done` in cycle k+17 (k+18 with parity).
  - `load_ready` high again in the following cycle.
- Minimum spacing between accepts: WIDTH+2 cycles (WIDTH+3 with parity).
- Each cycle with `enable` = 0 extends all of these by one cycle.
- All outputs are registered-state derived. The only combinational paths are from `enable` and `reset` to the qualified outputs.

## Configuration
- `WORD_SERIALIZER_PARITY_EN` defined:
  - The PARITY state exists.
  - One extra bit follows the data, with `serial_valid` = 1 and `frame_start` = 0.
  - Its value is the XOR of the accepted word (even parity), computed at accept.
- Not defined:
  - No PARITY state.
  - Frame length is exactly WIDTH bits.
  - SHIFT goes directly to DONE.

## Test plan
- Reset then idle, `enable` = 1, `load_valid` = 0 → `load_ready` = 1, `serial_valid` = 0, `done` never pulses.
- Accept 16'h8001:
  - `serial_out` = 1 on cycle k+1 with `frame_start` = 1.
  - Cycles k+2..k+15 carry 0.
  - Cycle k+16 carries 1.
  - `done` on cycle k+17.
  - `load_ready` = 1 on cycle k+18.
- Accept 16'hA5F0, then hold `load_valid` = 1 with 16'hFFFF throughout the frame → emitted bits 1010 0101 1111 0000; 16'hFFFF is accepted only once `load_ready` returns.
- Accept 16'h00FF, drop `enable` for 3 cycles after the 5th bit:
  - No `serial_valid` during the pause.
  - Remaining bits continue unchanged.
  - `done` is delayed exactly 3 cycles.
- Assert `reset` during the 8th bit of 16'h1234:
  - Next cycle: IDLE with `serial_valid` = 0.
  - No `done` pulse.
  - A fresh word sent afterwards serializes correctly.
- With `WORD_SERIALIZER_PARITY_EN`, accept 16'h0007 → 16 data bits, then parity bit 1 on cycle k+17, `done` on cycle k+18. Repeat with 16'h0003 → parity bit 0.
